// File: rtl/mem_arbiter_nch.sv
// mem_arbiter_nch: N-channel arbiter for a single request/response memory port.
// Selection is fixed-priority (channel 0 highest) or round-robin, chosen by RR_MODE.
// An accepted transaction is latched and held on the memory port until mem_resp.
// The completion pulse is then routed back to the owning channel only.
// Optional macro ARB_STARVE_GUARD_EN adds a per-channel wait counter. A channel
// that has waited STARVE_LIMIT grants is promoted above all non-starved channels.
module mem_arbiter_nch #(
    parameter int NUM_CH       = 2,
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MASK_W       = 2,
    parameter int RR_MODE      = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          req_read,
    input  logic [NUM_CH-1:0]          req_write,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    input  logic [NUM_CH*MASK_W-1:0]   req_wmask,
    output logic [NUM_CH-1:0]          req_resp,
    output logic [DATA_W-1:0]          req_rdata,
    output logic [NUM_CH-1:0]          grant,
    output logic                       busy,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [MASK_W-1:0]          mem_byte_enable,
    input  logic                       mem_resp,
    input  logic [DATA_W-1:0]          mem_rdata
);

    localparam int PTR_W = $clog2(NUM_CH);

    // Reject parameter sets the selection logic was not built for.
    if (NUM_CH < 2 || NUM_CH > 8 || STARVE_LIMIT < 1) begin : g_param_check
        $error("mem_arbiter_nch: NUM_CH must be 2..8 and STARVE_LIMIT >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic                  grant_event;
    logic                  txn_done;

    logic [NUM_CH-1:0]     active;
    logic                  win_found;
    logic [PTR_W-1:0]      win_idx;
    logic [PTR_W:0]        rr_sum;

    logic [NUM_CH-1:0]     sel_grant;
    logic [ADDR_W-1:0]     sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic [MASK_W-1:0]     sel_mask;
    logic                  sel_write;

    logic [NUM_CH-1:0]     grant_reg;
    logic                  mem_read_reg;
    logic                  mem_write_reg;
    logic [ADDR_W-1:0]     addr_reg;
    logic [DATA_W-1:0]     wdata_reg;
    logic [MASK_W-1:0]     mask_reg;
    logic [PTR_W-1:0]      rr_ptr_reg;

    // A channel is requesting when either its read or write line is high.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_active
        assign active[gi] = req_read[gi] | req_write[gi];
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]      wait_cnt_reg [NUM_CH];
    logic [NUM_CH-1:0]     starved;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_starved
        assign starved[gi] = active[gi] && (wait_cnt_reg[gi] == CNT_W'(STARVE_LIMIT));
    end

    // Count the grants a requesting channel loses; saturate at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                wait_cnt_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!active[i]) begin
                    wait_cnt_reg[i] <= '0;
                end else if (grant_event) begin
                    if (sel_grant[i]) begin
                        wait_cnt_reg[i] <= '0;
                    end else if (wait_cnt_reg[i] != CNT_W'(STARVE_LIMIT)) begin
                        wait_cnt_reg[i] <= wait_cnt_reg[i] + 1'b1;
                    end
                end
            end
        end
    end
`endif

    // Choose the winning channel index among the active requesters.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_sum    = '0;
        if (RR_MODE == 0) begin
            // Walk downwards so the lowest active index is the last one written.
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (active[i]) begin
                    win_found = 1'b1;
                    win_idx   = PTR_W'(i);
                end
            end
        end else begin
            // Search from pointer+1 upwards, wrapping modulo NUM_CH (any NUM_CH).
            for (int k = 0; k < NUM_CH; k++) begin
                rr_sum = {1'b0, rr_ptr_reg} + (PTR_W+1)'(k + 1);
                if (rr_sum >= (PTR_W+1)'(NUM_CH)) begin
                    rr_sum = rr_sum - (PTR_W+1)'(NUM_CH);
                end
                if (!win_found && active[rr_sum[PTR_W-1:0]]) begin
                    win_found = 1'b1;
                    win_idx   = rr_sum[PTR_W-1:0];
                end
            end
        end
`ifdef ARB_STARVE_GUARD_EN
        // Starved channels override the normal choice, lowest index first.
        if (|starved) begin
            win_found = 1'b1;
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (starved[i]) begin
                    win_idx = PTR_W'(i);
                end
            end
        end
`endif
    end

    // Pick out the winner's request payload and build its one-hot grant.
    always_comb begin
        sel_grant = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_mask  = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (win_idx == PTR_W'(i)) begin
                sel_grant[i] = win_found;
                sel_addr     = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata    = req_wdata[i*DATA_W +: DATA_W];
                sel_mask     = req_wmask[i*MASK_W +: MASK_W];
                sel_write    = req_write[i];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: accept a request in IDLE, finish on mem_resp in BUSY.
    always_comb begin
        state_next  = state_reg;
        grant_event = 1'b0;
        txn_done    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    state_next  = BUSY;
                    grant_event = 1'b1;
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    state_next = IDLE;
                    txn_done   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Latch the granted transaction and hold it until the memory completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_reg     <= '0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            mask_reg      <= '0;
            rr_ptr_reg    <= PTR_W'(NUM_CH - 1);
        end else if (grant_event) begin
            grant_reg     <= sel_grant;
            // Write wins when a channel illegally raises both lines.
            mem_read_reg  <= ~sel_write;
            mem_write_reg <= sel_write;
            addr_reg      <= sel_addr;
            wdata_reg     <= sel_wdata;
            mask_reg      <= sel_mask;
            rr_ptr_reg    <= win_idx;
        end else if (txn_done) begin
            grant_reg     <= '0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
        end
    end

    assign grant           = grant_reg;
    assign busy            = (state_reg == BUSY);
    assign mem_read        = mem_read_reg;
    assign mem_write       = mem_write_reg;
    assign mem_address     = addr_reg;
    assign mem_wdata       = wdata_reg;
    assign mem_byte_enable = mask_reg;
    // Completion goes straight through in the cycle mem_resp arrives.
    assign req_resp        = (state_reg == BUSY && mem_resp) ? grant_reg : '0;
    assign req_rdata       = (state_reg == BUSY) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter_nch.sv
// Testbench for mem_arbiter_nch: two instances with three channels each,
// instance 0 fixed priority and instance 1 round robin. A responder per
// instance answers each memory access 3 cycles after it starts with
// rdata = address ^ 16'hACDB. Expected transactions go into a queue and are
// checked by a monitor whenever an instance pulses req_resp.
module tb_mem_arbiter_nch;

    localparam int NCH  = 3;
    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int MW   = 2;
    localparam int NDUT = 2;

    typedef struct {
        int              dut;
        logic [NCH-1:0]  g;
        logic [AW-1:0]   addr;
        logic            wr;
        logic [DW-1:0]   wdata;
        logic [MW-1:0]   mask;
        logic [DW-1:0]   rdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NCH-1:0]    req_read        [NDUT];
    logic [NCH-1:0]    req_write       [NDUT];
    logic [NCH*AW-1:0] req_addr        [NDUT];
    logic [NCH*DW-1:0] req_wdata       [NDUT];
    logic [NCH*MW-1:0] req_wmask       [NDUT];
    logic [NCH-1:0]    req_resp        [NDUT];
    logic [DW-1:0]     req_rdata       [NDUT];
    logic [NCH-1:0]    grant           [NDUT];
    logic              busy            [NDUT];
    logic              mem_read        [NDUT];
    logic              mem_write       [NDUT];
    logic [AW-1:0]     mem_address     [NDUT];
    logic [DW-1:0]     mem_wdata       [NDUT];
    logic [MW-1:0]     mem_byte_enable [NDUT];
    logic              mem_resp        [NDUT];
    logic [DW-1:0]     mem_rdata       [NDUT];
    logic              auto_resp       [NDUT];
    logic              man_resp        [NDUT];
    logic              resp_en         [NDUT];

    txn_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        mem_arbiter_nch #(
            .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW),
            .RR_MODE(gi), .STARVE_LIMIT(2)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req_read(req_read[gi]), .req_write(req_write[gi]),
            .req_addr(req_addr[gi]), .req_wdata(req_wdata[gi]), .req_wmask(req_wmask[gi]),
            .req_resp(req_resp[gi]), .req_rdata(req_rdata[gi]), .grant(grant[gi]),
            .busy(busy[gi]), .mem_read(mem_read[gi]), .mem_write(mem_write[gi]),
            .mem_address(mem_address[gi]), .mem_wdata(mem_wdata[gi]),
            .mem_byte_enable(mem_byte_enable[gi]),
            .mem_resp(mem_resp[gi]), .mem_rdata(mem_rdata[gi])
        );

        assign mem_resp[gi] = auto_resp[gi] | man_resp[gi];

        // Memory responder: fixed 3-cycle latency, data derived from address.
        initial begin
            int cnt;
            cnt = 0;
            auto_resp[gi] = 1'b0;
            mem_rdata[gi] = '0;
            forever begin
                @(posedge clk);
                #1;
                if (!resp_en[gi]) begin
                    cnt = 0;
                    auto_resp[gi] = 1'b0;
                end else if (auto_resp[gi]) begin
                    auto_resp[gi] = 1'b0;
                end else if (mem_read[gi] || mem_write[gi]) begin
                    cnt++;
                    if (cnt == 3) begin
                        auto_resp[gi] = 1'b1;
                        mem_rdata[gi] = mem_address[gi] ^ 16'hACDB;
                        cnt = 0;
                    end
                end
            end
        end

        // Monitor: compare each completion with the scoreboard, then the bubble.
        initial begin
            txn_t e;
            bit   pend_bubble;
            pend_bubble = 1'b0;
            forever begin
                @(negedge clk);
                if (pend_bubble) begin
                    chk("bubble_busy", 32'(busy[gi]), 32'd0);
                    chk("bubble_grant_resp", 32'({grant[gi], req_resp[gi]}), 32'd0);
                    pend_bubble = 1'b0;
                end
                if (req_resp[gi] !== '0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_resp", 32'(req_resp[gi]), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        $display("dut%0d resp ch_mask=%b addr=%h wr=%0d rdata=%h", gi,
                                 req_resp[gi], mem_address[gi], mem_write[gi], req_rdata[gi]);
                        chk("sb_dut", 32'(gi), 32'(e.dut));
                        chk("sb_req_resp", 32'(req_resp[gi]), 32'(e.g));
                        chk("sb_grant", 32'(grant[gi]), 32'(e.g));
                        chk("sb_addr", 32'(mem_address[gi]), 32'(e.addr));
                        chk("sb_mem_write", 32'(mem_write[gi]), 32'(e.wr));
                        chk("sb_mem_read", 32'(mem_read[gi]), 32'(!e.wr));
                        chk("sb_rdata", 32'(req_rdata[gi]), 32'(e.rdata));
                        if (e.wr) begin
                            chk("sb_wdata", 32'(mem_wdata[gi]), 32'(e.wdata));
                            chk("sb_mask", 32'(mem_byte_enable[gi]), 32'(e.mask));
                        end
                    end
                    pend_bubble = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input logic [1:0] ch, input logic [15:0] a, input logic wr,
                        input logic [15:0] wd, input logic [1:0] m, input logic [15:0] rd);
        txn_t t;
        t.dut   = d;
        t.g     = 3'b001 << ch;
        t.addr  = a;
        t.wr    = wr;
        t.wdata = wd;
        t.mask  = m;
        t.rdata = rd;
        exp_q.push_back(t);
    endtask

    task automatic set_req(input bit d, input logic [1:0] ch, input logic rd, input logic wr,
                           input logic [15:0] a, input logic [15:0] wd, input logic [1:0] m);
        req_read[d][ch]  = rd;
        req_write[d][ch] = wr;
        req_addr[d][{ch, 4'b0000} +: AW]  = a;
        req_wdata[d][{ch, 4'b0000} +: DW] = wd;
        req_wmask[d][{ch, 1'b0} +: MW]    = m;
    endtask

    // Wait (bounded) for the next completion on instance d, check its channel, optionally drop.
    task automatic serve(input bit d, input logic [1:0] exp_ch, input bit drop);
        int ch;
        ch = -1;
        for (int k = 0; k < 60 && ch < 0; k++) begin
            @(negedge clk);
            for (int i = 0; i < NCH; i++) begin
                if (req_resp[d][i] === 1'b1) ch = i;
            end
        end
        if (ch < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL resp_timeout: dut%0d no completion, required channel %0d", d, exp_ch);
        end else begin
            chk("resp_channel", 32'(ch), 32'(exp_ch));
        end
        if (drop) begin
            tick();
            req_read[d][exp_ch]  = 1'b0;
            req_write[d][exp_ch] = 1'b0;
        end
    endtask

    task automatic chk_idle(input bit d, input string tag);
        chk({tag, "_grant"}, 32'(grant[d]), 32'd0);
        chk({tag, "_busy_rd_wr"}, 32'({busy[d], mem_read[d], mem_write[d]}), 32'd0);
        chk({tag, "_addr"}, 32'(mem_address[d]), 32'd0);
        chk({tag, "_wdata_mask"}, 32'({mem_wdata[d], mem_byte_enable[d]}), 32'd0);
        chk({tag, "_resp_rdata"}, 32'({req_resp[d], req_rdata[d]}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            req_read[d]  = '0;
            req_write[d] = '0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            req_wmask[d] = '0;
            man_resp[d]  = 1'b0;
            resp_en[d]   = 1'b1;
        end
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk_idle(1'b0, "reset0");
        chk_idle(1'b1, "reset1");
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Single ch1 read, 1-cycle request-to-mem_read latency, rdata 0xBEEF
        push(0, 2'd1, 16'h1234, 1'b0, 16'h0000, 2'b00, 16'hBEEF);
        set_req(1'b0, 2'd1, 1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00);
        @(negedge clk);
        chk("t1_mem_read_before", 32'({mem_read[0], busy[0]}), 32'd0);
        @(negedge clk);
        chk("t1_mem_read_after", 32'(mem_read[0]), 32'd1);
        chk("t1_grant", 32'(grant[0]), 32'b010);
        chk("t1_addr", 32'(mem_address[0]), 32'h1234);
        serve(1'b0, 2'd1, 1'b1);
        repeat (3) tick();

        // Fixed priority, ch0 and ch1 both held
`ifdef ARB_STARVE_GUARD_EN
        push(0, 2'd0, 16'h0010, 1'b0, 16'h0, 2'b00, 16'hACCB);
        push(0, 2'd0, 16'h0010, 1'b0, 16'h0, 2'b00, 16'hACCB);
        push(0, 2'd1, 16'h0020, 1'b0, 16'h0, 2'b00, 16'hACFB);
        push(0, 2'd0, 16'h0010, 1'b0, 16'h0, 2'b00, 16'hACCB);
`else
        push(0, 2'd0, 16'h0010, 1'b0, 16'h0, 2'b00, 16'hACCB);
        push(0, 2'd0, 16'h0010, 1'b0, 16'h0, 2'b00, 16'hACCB);
        push(0, 2'd0, 16'h0010, 1'b0, 16'h0, 2'b00, 16'hACCB);
        push(0, 2'd1, 16'h0020, 1'b0, 16'h0, 2'b00, 16'hACFB);
`endif
        set_req(1'b0, 2'd0, 1'b1, 1'b0, 16'h0010, 16'h0000, 2'b00);
        set_req(1'b0, 2'd1, 1'b1, 1'b0, 16'h0020, 16'h0000, 2'b00);
`ifdef ARB_STARVE_GUARD_EN
        serve(1'b0, 2'd0, 1'b0);
        serve(1'b0, 2'd0, 1'b0);
        serve(1'b0, 2'd1, 1'b1);
        serve(1'b0, 2'd0, 1'b1);
`else
        serve(1'b0, 2'd0, 1'b0);
        serve(1'b0, 2'd0, 1'b0);
        serve(1'b0, 2'd0, 1'b1);
        serve(1'b0, 2'd1, 1'b1);
`endif
        repeat (3) tick();

        // ch0 write held stable while its request lines change mid-transaction
        push(0, 2'd0, 16'h0040, 1'b1, 16'hA5A5, 2'b01, 16'hAC9B);
        set_req(1'b0, 2'd0, 1'b0, 1'b1, 16'h0040, 16'hA5A5, 2'b01);
        @(negedge clk);
        @(negedge clk);
        chk("t4_granted_write", 32'({grant[0], mem_write[0]}), 32'b0011);
        tick();
        set_req(1'b0, 2'd0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 2'b10);
        @(negedge clk);
        chk("t4_addr_held", 32'(mem_address[0]), 32'h0040);
        chk("t4_wdata_held", 32'(mem_wdata[0]), 32'hA5A5);
        chk("t4_mask_held", 32'(mem_byte_enable[0]), 32'b01);
        chk("t4_write_held", 32'({mem_write[0], mem_read[0]}), 32'b10);
        serve(1'b0, 2'd0, 1'b1);
        repeat (3) tick();

        // Round robin on a 3-channel instance, all channels held
        push(1, 2'd0, 16'h0100, 1'b0, 16'h0, 2'b00, 16'hADDB);
        push(1, 2'd1, 16'h0101, 1'b0, 16'h0, 2'b00, 16'hADDA);
        push(1, 2'd2, 16'h0102, 1'b0, 16'h0, 2'b00, 16'hADD9);
        push(1, 2'd0, 16'h0100, 1'b0, 16'h0, 2'b00, 16'hADDB);
        push(1, 2'd1, 16'h0101, 1'b0, 16'h0, 2'b00, 16'hADDA);
        push(1, 2'd2, 16'h0102, 1'b0, 16'h0, 2'b00, 16'hADD9);
        set_req(1'b1, 2'd0, 1'b1, 1'b0, 16'h0100, 16'h0000, 2'b00);
        set_req(1'b1, 2'd1, 1'b1, 1'b0, 16'h0101, 16'h0000, 2'b00);
        set_req(1'b1, 2'd2, 1'b1, 1'b0, 16'h0102, 16'h0000, 2'b00);
        serve(1'b1, 2'd0, 1'b0);
        serve(1'b1, 2'd1, 1'b0);
        serve(1'b1, 2'd2, 1'b0);
        serve(1'b1, 2'd0, 1'b0);
        serve(1'b1, 2'd1, 1'b0);
        serve(1'b1, 2'd2, 1'b1);
        req_read[1] = '0;
        repeat (3) tick();

        // Reset while BUSY, then a stray mem_resp after release
        resp_en[0] = 1'b0;
        set_req(1'b0, 2'd2, 1'b1, 1'b0, 16'h0300, 16'h0000, 2'b00);
        @(negedge clk);
        @(negedge clk);
        chk("t5_busy_before_reset", 32'({busy[0], grant[0]}), 32'b1100);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle(1'b0, "t5_async");
        req_read[0] = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        man_resp[0] = 1'b1;
        @(negedge clk);
        chk("t5_stray_resp", 32'(req_resp[0]), 32'd0);
        chk("t5_stray_busy_grant", 32'({busy[0], grant[0]}), 32'd0);
        tick();
        man_resp[0] = 1'b0;
        resp_en[0]  = 1'b1;
        repeat (3) tick();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
